// File: rtl/decode_stage.sv
// decode_stage: instruction decode with branch/jump redirect control.
// Plain instructions pass to execute one cycle later. JMP, BEQZ and BNEZ are
// consumed here and request a fetch redirect. A conditional branch whose zero
// flag is not yet available parks in WAIT_FLAG, stalling fetch, until the flag
// arrives or the wait counter times out (resolved not-taken).
// Optional feature: define DECODE_PERF_CNT_EN to build the saturating
// taken-branch counter on br_count; otherwise br_count is tied to zero.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [6:0]  pc_in,
  input  logic        bubble_in,
  input  logic        zero_flag,
  input  logic        zero_valid,
  output logic        dec,
  output logic [6:0]  pc_mux,
  output logic        enbl,
  output logic [31:0] instr_out,
  output logic [6:0]  pc_out,
  output logic        valid_out,
  output logic        timeout,
  output logic [15:0] br_count
);

  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [3:0] WAIT_LAST = 4'd14;

  typedef enum logic [1:0] {RUN, WAIT_FLAG, REDIRECT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic        dec_q, dec_d;
  logic [6:0]  pc_mux_q, pc_mux_d;
  logic        enbl_q, enbl_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [6:0]  pc_out_q, pc_out_d;
  logic        valid_out_q, valid_out_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [6:0]  tgt_q, tgt_d;
  logic        is_ne_q, is_ne_d;

  logic [5:0]  opcode;
  logic        accept;
  logic [6:0]  br_tgt;

  // Branch condition: BEQZ takes on zero, BNEZ takes on non-zero.
  function automatic logic br_taken(input logic is_ne, input logic flag);
    return is_ne ? ~flag : flag;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    opcode      = instr[31:26];
    accept      = (state_q == RUN) && !bubble_in;
    br_tgt      = pc_in + instr[6:0];
    state_d     = state_q;
    pc_mux_d    = pc_mux_q;
    instr_out_d = instr_out_q;
    pc_out_d    = pc_out_q;
    valid_out_d = 1'b0;
    timeout_d   = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    tgt_d       = tgt_q;
    is_ne_d     = is_ne_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (opcode == OP_JMP) begin
            state_d  = REDIRECT;
            pc_mux_d = instr[6:0];
          end else if (opcode == OP_BEQZ || opcode == OP_BNEZ) begin
            if (zero_valid) begin
              if (br_taken(opcode == OP_BNEZ, zero_flag)) begin
                state_d  = REDIRECT;
                pc_mux_d = br_tgt;
              end
            end else begin
              state_d    = WAIT_FLAG;
              tgt_d      = br_tgt;
              is_ne_d    = (opcode == OP_BNEZ);
              wait_cnt_d = 4'd0;
            end
          end else begin
            instr_out_d = instr;
            pc_out_d    = pc_in;
            valid_out_d = 1'b1;
          end
        end
      end
      WAIT_FLAG: begin
        // A valid flag wins over both a bubble and the timeout.
        if (zero_valid) begin
          if (br_taken(is_ne_q, zero_flag)) begin
            state_d  = REDIRECT;
            pc_mux_d = tgt_q;
          end else begin
            state_d = RUN;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          timeout_d  = 1'b1;
          state_d    = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      REDIRECT: state_d = FLUSH;
      FLUSH:    state_d = RUN;
      default:  state_d = RUN;
    endcase
    dec_d  = (state_d == REDIRECT);
    enbl_d = (state_d != WAIT_FLAG);
  end

  // State and output registers; reset abandons any pending branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      dec_q       <= 1'b0;
      pc_mux_q    <= 7'd0;
      enbl_q      <= 1'b1;
      instr_out_q <= 32'd0;
      pc_out_q    <= 7'd0;
      valid_out_q <= 1'b0;
      timeout_q   <= 1'b0;
      wait_cnt_q  <= 4'd0;
      tgt_q       <= 7'd0;
      is_ne_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      pc_mux_q    <= pc_mux_d;
      enbl_q      <= enbl_d;
      instr_out_q <= instr_out_d;
      pc_out_q    <= pc_out_d;
      valid_out_q <= valid_out_d;
      timeout_q   <= timeout_d;
      wait_cnt_q  <= wait_cnt_d;
      tgt_q       <= tgt_d;
      is_ne_q     <= is_ne_d;
    end
  end

  assign dec       = dec_q;
  assign pc_mux    = pc_mux_q;
  assign enbl      = enbl_q;
  assign instr_out = instr_out_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_out_q;
  assign timeout   = timeout_q;

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] br_count_q, br_count_d;

  // Saturating count of REDIRECT entries.
  always_comb begin
    br_count_d = br_count_q;
    if (state_d == REDIRECT && state_q != REDIRECT && br_count_q != 16'hFFFF)
      br_count_d = br_count_q + 16'd1;
  end

  // Taken-branch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) br_count_q <= 16'd0;
    else     br_count_q <= br_count_d;
  end

  assign br_count = br_count_q;
`else
  assign br_count = 16'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [6:0]  pc_in;
  logic        bubble_in, zero_flag, zero_valid;
  logic        dec, enbl, valid_out, timeout;
  logic [6:0]  pc_mux, pc_out;
  logic [31:0] instr_out;
  logic [15:0] br_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_br;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in), .bubble_in(bubble_in),
    .zero_flag(zero_flag), .zero_valid(zero_valid), .dec(dec), .pc_mux(pc_mux),
    .enbl(enbl), .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .timeout(timeout), .br_count(br_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [6:0] p, input logic b,
                       input logic zv, input logic zf);
    instr = i; pc_in = p; bubble_in = b; zero_valid = zv; zero_flag = zf;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(32'h0, 7'd0, 1'b1, 1'b0, 1'b0);
    #3;
    checks++; if (dec !== 1'b0) begin errors++; $display("FAIL reset_dec got=%b exp=0", dec); end
    checks++; if (enbl !== 1'b1) begin errors++; $display("FAIL reset_enbl got=%b exp=1", enbl); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (pc_mux !== 7'd0) begin errors++; $display("FAIL reset_pc_mux got=%0d exp=0", pc_mux); end
    checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_instr_out got=%h exp=0", instr_out); end
    checks++; if (pc_out !== 7'd0) begin errors++; $display("FAIL reset_pc_out got=%0d exp=0", pc_out); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (br_count !== 16'd0) begin errors++; $display("FAIL reset_br_count got=%0d exp=0", br_count); end
    step;
    // Release reset mid-cycle; the instruction on the very next edge is accepted.
    rst = 1'b0;
    drive(32'h0000_0011, 7'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_plain;
    step;
    checks++; if (instr_out !== 32'h0000_0011) begin errors++; $display("FAIL plain_instr got=%h exp=00000011", instr_out); end
    checks++; if (pc_out !== 7'd5) begin errors++; $display("FAIL plain_pc got=%0d exp=5", pc_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL plain_valid got=%b exp=1", valid_out); end
    drive(32'hABCD_0123, 7'd6, 1'b0, 1'b0, 1'b0);
    step;
    checks++; if (instr_out !== 32'hABCD_0123 || pc_out !== 7'd6 || valid_out !== 1'b1) begin
      errors++; $display("FAIL plain2 got=%h/%0d/%b exp=abcd0123/6/1", instr_out, pc_out, valid_out); end
    drive(32'h0000_0077, 7'd7, 1'b1, 1'b0, 1'b0);
    step;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%b exp=0", valid_out); end
  endtask

  task automatic test_beqz_wrap;
    drive(32'h1000_000A, 7'd120, 1'b0, 1'b1, 1'b1);
    step;
    drive(32'h0000_0022, 7'd0, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_PERF_CNT_EN
    exp_br = 16'd1;
`else
    exp_br = 16'd0;
`endif
    checks++; if (dec !== 1'b1) begin errors++; $display("FAIL beqz_dec got=%b exp=1", dec); end
    checks++; if (pc_mux !== 7'd2) begin errors++; $display("FAIL beqz_pc_mux got=%0d exp=2", pc_mux); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL beqz_valid got=%b exp=0", valid_out); end
    checks++; if (br_count !== exp_br) begin errors++; $display("FAIL beqz_br_count got=%0d exp=%0d", br_count, exp_br); end
    step;  // FLUSH
    step;  // back in RUN
  endtask

  task automatic test_jmp;
    drive(32'h0800_0040, 7'd10, 1'b0, 1'b0, 1'b0);
    step;
    drive(32'h0000_0022, 7'd11, 1'b0, 1'b0, 1'b0);
    checks++; if (dec !== 1'b1 || pc_mux !== 7'd64) begin errors++; $display("FAIL jmp_redirect got=%b/%0d exp=1/64", dec, pc_mux); end
    checks++; if (enbl !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL jmp_enbl_valid got=%b/%b exp=1/0", enbl, valid_out); end
    step;
    drive(32'h0000_0033, 7'd64, 1'b0, 1'b0, 1'b0);
    checks++; if (dec !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL jmp_redirect_len got=%b/%b exp=0/0", dec, valid_out); end
    checks++; if (pc_mux !== 7'd64) begin errors++; $display("FAIL jmp_pc_mux_hold got=%0d exp=64", pc_mux); end
    step;
    drive(32'h0000_0044, 7'd65, 1'b0, 1'b0, 1'b0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL jmp_flush_discard got=%b exp=0", valid_out); end
    step;
    checks++; if (valid_out !== 1'b1 || instr_out !== 32'h0000_0044 || pc_out !== 7'd65) begin
      errors++; $display("FAIL jmp_resume got=%b/%h/%0d exp=1/00000044/65", valid_out, instr_out, pc_out); end
`ifdef DECODE_PERF_CNT_EN
    exp_br = 16'd2;
`else
    exp_br = 16'd0;
`endif
    checks++; if (br_count !== exp_br) begin errors++; $display("FAIL jmp_br_count got=%0d exp=%0d", br_count, exp_br); end
  endtask

  task automatic test_bnez_wait;
    drive(32'h1400_0003, 7'd20, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step;
      drive(32'h0000_0099, 7'd21, 1'b0, 1'b0, 1'b0);
      checks++; if (enbl !== 1'b0 || dec !== 1'b0 || valid_out !== 1'b0) begin
        errors++; $display("FAIL bnez_wait%0d got enbl/dec/valid=%b/%b/%b exp=0/0/0", c, enbl, dec, valid_out); end
    end
    // Flag arrives together with a bubble: flag is used, BNEZ not taken.
    drive(32'h0000_0099, 7'd21, 1'b1, 1'b1, 1'b1);
    step;
    checks++; if (enbl !== 1'b1 || dec !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL bnez_resolve got enbl/dec/valid=%b/%b/%b exp=1/0/0", enbl, dec, valid_out); end
    drive(32'h0000_0055, 7'd22, 1'b0, 1'b0, 1'b0);
    step;
    checks++; if (dec !== 1'b0 || valid_out !== 1'b1 || instr_out !== 32'h0000_0055) begin
      errors++; $display("FAIL bnez_after got dec/valid/instr=%b/%b/%h exp=0/1/00000055", dec, valid_out, instr_out); end
  endtask

  task automatic test_timeout;
    int n;
    logic early_bad;
    drive(32'h1000_0005, 7'd30, 1'b0, 1'b0, 1'b0);
    step;
    drive(32'h0000_0066, 7'd31, 1'b1, 1'b0, 1'b0);
    n = 0;
    early_bad = 1'b0;
    while (timeout !== 1'b1 && n < 30) begin
      if (enbl !== 1'b0) early_bad = 1'b1;
      step;
      n++;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL timeout_cycles got=%0d exp=15", n); end
    checks++; if (early_bad !== 1'b0) begin errors++; $display("FAIL timeout_stall got=%b exp=0", early_bad); end
    checks++; if (enbl !== 1'b1 || dec !== 1'b0) begin errors++; $display("FAIL timeout_run got enbl/dec=%b/%b exp=1/0", enbl, dec); end
    drive(32'h0000_0066, 7'd31, 1'b0, 1'b0, 1'b0);
    step;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got=%b exp=0", timeout); end
    checks++; if (valid_out !== 1'b1 || instr_out !== 32'h0000_0066) begin
      errors++; $display("FAIL timeout_resume got=%b/%h exp=1/00000066", valid_out, instr_out); end
  endtask

  task automatic test_reset_redirect;
    drive(32'h0800_0012, 7'd40, 1'b0, 1'b0, 1'b0);
    step;
    checks++; if (dec !== 1'b1) begin errors++; $display("FAIL rstred_pre got=%b exp=1", dec); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dec !== 1'b0 || enbl !== 1'b1 || valid_out !== 1'b0) begin
      errors++; $display("FAIL rstred_async got dec/enbl/valid=%b/%b/%b exp=0/1/0", dec, enbl, valid_out); end
    step;
    rst = 1'b0;
    drive(32'h0000_00AA, 7'd41, 1'b0, 1'b0, 1'b0);
    step;
    checks++; if (dec !== 1'b0 || valid_out !== 1'b1 || instr_out !== 32'h0000_00AA) begin
      errors++; $display("FAIL rstred_first got dec/valid/instr=%b/%b/%h exp=0/1/000000aa", dec, valid_out, instr_out); end
    // Reset during WAIT_FLAG abandons the branch: a later taken flag is ignored.
    drive(32'h1000_0004, 7'd50, 1'b0, 1'b0, 1'b0);
    step;
    checks++; if (enbl !== 1'b0) begin errors++; $display("FAIL rstwait_pre got=%b exp=0", enbl); end
    #2 rst = 1'b1;
    #1;
    checks++; if (enbl !== 1'b1) begin errors++; $display("FAIL rstwait_async got=%b exp=1", enbl); end
    step;
    rst = 1'b0;
    drive(32'h0000_00BB, 7'd51, 1'b1, 1'b1, 1'b1);
    step;
    checks++; if (dec !== 1'b0 || enbl !== 1'b1 || valid_out !== 1'b0) begin
      errors++; $display("FAIL rstwait_abandon got dec/enbl/valid=%b/%b/%b exp=0/1/0", dec, enbl, valid_out); end
  endtask

  initial begin
    test_reset;
    test_plain;
    test_beqz_wrap;
    test_jmp;
    test_bnez_wait;
    test_timeout;
    test_reset_redirect;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
